fetch_queue: RTL



---
 rtl/simple_processor_pkg.sv | 14 +
 rtl/fetch_queue.sv | 113 +++++++++++
 2 files changed

// File: rtl/simple_processor_pkg.sv
// Shared processor-wide widths and payload types.
// Includes the fetch queue entry layout and its default depth.
package simple_processor_pkg;

    localparam int unsigned ADDR_WIDTH        = 16;
    localparam int unsigned DATA_WIDTH        = 32;
    localparam int unsigned FETCH_QUEUE_DEPTH = 2;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue: buffers {pc, instr} responses from imem for the decoder.
// Optional same-cycle bypass of an empty queue with FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import simple_processor_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = simple_processor_pkg::ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = simple_processor_pkg::DATA_WIDTH,
    parameter int unsigned DEPTH      = simple_processor_pkg::FETCH_QUEUE_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  arst_i,
    input  logic                  imem_ack_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic [ADDR_WIDTH-1:0] fetch_pc_i,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    input  logic                  instr_ready_i,
    output logic                  overflow_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    logic               head_valid;
    logic               full;
    logic               push;
    logic               pop;
    logic               bypass_take;
    entry_t             head;

    assign head_valid = (count_q != '0);
    assign full       = (count_q == CNT_W'(DEPTH));
    assign head       = mem[rd_ptr_q];
    assign pop        = head_valid && instr_ready_i && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards a live response straight to the decoder.
    logic bypass_valid;
    assign bypass_valid  = !head_valid && imem_ack_i && !flush_i;
    assign bypass_take   = bypass_valid && instr_ready_i;
    assign instr_valid_o = head_valid || bypass_valid;
    assign instr_o       = head_valid ? head.instr : (bypass_valid ? imem_rdata_i : '0);
    assign instr_pc_o    = head_valid ? head.pc    : (bypass_valid ? fetch_pc_i   : '0);
`else
    assign bypass_take   = 1'b0;
    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? head.instr : '0;
    assign instr_pc_o    = head_valid ? head.pc    : '0;
`endif

    assign push       = imem_ack_i && (!full || pop) && !flush_i && !bypass_take;
    assign full_o     = full;
    assign overflow_o = overflow_q;

    // Next-state: flush wins over everything else.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (imem_ack_i && full && !pop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is intentionally not reset; outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= '{pc: fetch_pc_i, instr: imem_rdata_i};
        end
    end

endmodule
